// File: rtl/port_err_monitor.sv
// Link/memory error monitor on the SRIO single-access bus: saturating per-link
// error counters with atomic snapshot/clear, W1C sticky flags and a maskable irq.
module port_err_monitor #(
    parameter int N_LINK = 4,
    parameter int MEM_N  = 3,
    parameter int CNT_W  = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              srio_single_rdn,
    input  logic              srio_single_wrn,
    input  logic              srio_single_csn,
    input  logic [7:0]        srio_single_addr,
    input  logic [31:0]       srio_single_dout,
    output logic [31:0]       srio_single_din,
    input  logic [N_LINK-1:0] link_err,
    input  logic [N_LINK-1:0] link_up,
    input  logic [MEM_N-1:0]  mem_init_done,
    input  logic [MEM_N-1:0]  mem_err,
    output logic              irq
);

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_MEM_STAT = 8'h04;
    localparam logic [7:0] ADDR_STICKY   = 8'h08;
    localparam logic [7:0] ADDR_IRQ_MASK = 8'h0C;
    localparam logic [7:0] ADDR_CTRL     = 8'h10;
    localparam logic [7:0] ADDR_LINK_UP  = 8'h14;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              rd_en;
    logic              wr_act;
    logic              wr_q;
    logic              wr_pulse;
    logic              wr_sticky;
    logic              wr_mask;
    logic              wr_ctrl;
    logic              do_snap;
    logic              do_clr;

    logic [CNT_W-1:0]  cnt      [N_LINK];
    logic [CNT_W-1:0]  snap_cnt [N_LINK];

    logic [N_LINK-1:0] link_up_q;
    logic [N_LINK-1:0] link_fall;
    logic [N_LINK-1:0] link_sticky;
    logic [N_LINK-1:0] link_mask;
    logic [N_LINK-1:0] link_w1c;
    logic [MEM_N-1:0]  mem_sticky;
    logic [MEM_N-1:0]  mem_mask;
    logic [MEM_N-1:0]  mem_w1c;

    logic [31:0]       sticky_word;
    logic [31:0]       mask_word;
    logic [31:0]       mem_stat_word;
    logic [31:0]       link_up_word;
    logic [31:0]       rd_data;
    logic              dout_unused;

    assign dout_unused = ^srio_single_dout;

    // A read in the same cycle as a write suppresses the write entirely.
    assign rd_en     = ~srio_single_rdn & ~srio_single_csn;
    assign wr_act    = ~srio_single_wrn & ~srio_single_csn;
    assign wr_pulse  = wr_act & ~wr_q & ~rd_en;
    assign wr_sticky = wr_pulse & (srio_single_addr == ADDR_STICKY);
    assign wr_mask   = wr_pulse & (srio_single_addr == ADDR_IRQ_MASK);
    assign wr_ctrl   = wr_pulse & (srio_single_addr == ADDR_CTRL);
    assign do_snap   = wr_ctrl & (srio_single_dout[0] | srio_single_dout[2]);
    assign do_clr    = wr_ctrl & (srio_single_dout[1] | srio_single_dout[2]);

    assign link_fall = link_up_q & ~link_up;
    assign link_w1c  = wr_sticky ? srio_single_dout[N_LINK-1:0] : '0;
    assign mem_w1c   = wr_sticky ? srio_single_dout[16 +: MEM_N] : '0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= wr_act;
        end
    end

    // A clear coinciding with an error event leaves that event counted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_LINK; i++) begin
                cnt[i]      <= '0;
                snap_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LINK; i++) begin
                if (do_snap) begin
                    snap_cnt[i] <= cnt[i];
                end
                if (do_clr) begin
                    cnt[i] <= link_err[i] ? CNT_W'(1) : '0;
                end else if (link_err[i] && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            link_up_q   <= '0;
            link_sticky <= '0;
            mem_sticky  <= '0;
            link_mask   <= '0;
            mem_mask    <= '0;
            irq         <= 1'b0;
        end else begin
            link_up_q   <= link_up;
            link_sticky <= (link_sticky & ~link_w1c) | link_err | link_fall;
            mem_sticky  <= (mem_sticky & ~mem_w1c) | mem_err;
            if (wr_mask) begin
                link_mask <= srio_single_dout[N_LINK-1:0];
                mem_mask  <= srio_single_dout[16 +: MEM_N];
            end
            irq <= (|(link_sticky & link_mask)) | (|(mem_sticky & mem_mask));
        end
    end

    always_comb begin
        sticky_word                 = '0;
        mask_word                   = '0;
        mem_stat_word               = '0;
        link_up_word                = '0;
        sticky_word[N_LINK-1:0]     = link_sticky;
        sticky_word[16 +: MEM_N]    = mem_sticky;
        mask_word[N_LINK-1:0]       = link_mask;
        mask_word[16 +: MEM_N]      = mem_mask;
        mem_stat_word[MEM_N-1:0]    = mem_err;
        mem_stat_word[16 +: MEM_N]  = mem_init_done;
        link_up_word[N_LINK-1:0]    = link_up;
    end

    // Snapshot window starts at 0x20; anything past the last link reads 0.
    always_comb begin
        rd_data = '0;
        case (srio_single_addr)
            ADDR_ID:       rd_data = {16'h5045, 8'(N_LINK), 8'h02};
            ADDR_MEM_STAT: rd_data = mem_stat_word;
            ADDR_STICKY:   rd_data = sticky_word;
            ADDR_IRQ_MASK: rd_data = mask_word;
            ADDR_CTRL:     rd_data = '0;
            ADDR_LINK_UP:  rd_data = link_up_word;
            default: begin
                for (int i = 0; i < N_LINK; i++) begin
                    if (srio_single_addr == 8'(32 + 4 * i)) begin
                        rd_data = 32'(snap_cnt[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            srio_single_din <= '0;
        end else if (rd_en) begin
            srio_single_din <= rd_data;
        end
    end

endmodule

// File: tb/tb_port_err_monitor.sv
// Directed bench for port_err_monitor (N_LINK=4, MEM_N=3, CNT_W=4).
module tb_port_err_monitor;

    localparam int N_LINK = 4;
    localparam int MEM_N  = 3;
    localparam int CNT_W  = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              rdn, wrn, csn;
    logic [7:0]        addr;
    logic [31:0]       dout;
    logic [31:0]       din;
    logic [N_LINK-1:0] link_err, link_up;
    logic [MEM_N-1:0]  mem_init_done, mem_err;
    logic              irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] rv;

    port_err_monitor #(.N_LINK(N_LINK), .MEM_N(MEM_N), .CNT_W(CNT_W)) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .srio_single_rdn  (rdn),
        .srio_single_wrn  (wrn),
        .srio_single_csn  (csn),
        .srio_single_addr (addr),
        .srio_single_dout (dout),
        .srio_single_din  (din),
        .link_err         (link_err),
        .link_up          (link_up),
        .mem_init_done    (mem_init_done),
        .mem_err          (mem_err),
        .irq              (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        csn = 1'b0; wrn = 1'b0; addr = a; dout = d;
        @(negedge sys_clk);
        csn = 1'b1; wrn = 1'b1;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge sys_clk);
        csn = 1'b0; rdn = 1'b0; addr = a;
        @(negedge sys_clk);
        csn = 1'b1; rdn = 1'b1;
        d = din;
    endtask

    task automatic pulse_err(input logic [N_LINK-1:0] m, input int n);
        @(negedge sys_clk);
        link_err = m;
        repeat (n) @(negedge sys_clk);
        link_err = '0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        rdn = 1'b1; wrn = 1'b1; csn = 1'b1;
        addr = '0; dout = '0;
        link_err = '0; link_up = '0;
        mem_init_done = '0; mem_err = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // reset state and decode
        check("rst_din", din, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        bus_read(8'h00, rv); check("id", rv, 32'h5045_0402);
        bus_read(8'h20, rv); check("snap0_rst", rv, 32'h0);
        bus_read(8'h10, rv); check("ctrl_rd0", rv, 32'h0);
        bus_read(8'h18, rv); check("unmapped", rv, 32'h0);
        bus_read(8'h30, rv); check("snap_oob", rv, 32'h0);

        // link 2 counts 5 events, snapshot
        pulse_err(4'b0100, 5);
        bus_write(8'h10, 32'h1);
        bus_read(8'h28, rv); check("snap2", rv, 32'h5);
        bus_read(8'h20, rv); check("snap0", rv, 32'h0);
        bus_read(8'h2C, rv); check("snap3", rv, 32'h0);
        bus_read(8'h08, rv); check("sticky_l2", rv, 32'h4);

        // live status, link_up falls, mem_err sticky
        link_up = 4'b1010;
        @(negedge sys_clk);
        bus_read(8'h14, rv); check("link_up", rv, 32'hA);
        mem_init_done = 3'b101; mem_err = 3'b010;
        bus_read(8'h04, rv); check("mem_stat", rv, 32'h0005_0002);
        mem_err = '0; link_up = '0;
        repeat (2) @(negedge sys_clk);
        bus_read(8'h08, rv); check("sticky_fall", rv, 32'h0002_000E);
        bus_write(8'h08, 32'h2);
        bus_read(8'h08, rv); check("sticky_w1c", rv, 32'h0002_000C);

        // saturation with CNT_W=4
        bus_write(8'h10, 32'h2);
        pulse_err(4'b0001, 20);
        bus_write(8'h10, 32'h1);
        bus_read(8'h20, rv); check("sat", rv, 32'hF);
        @(negedge sys_clk);
        link_err = 4'b0001; csn = 1'b0; wrn = 1'b0; addr = 8'h10; dout = 32'h4;
        @(negedge sys_clk);
        link_err = '0; csn = 1'b1; wrn = 1'b1;
        bus_read(8'h20, rv); check("snapclr_snap", rv, 32'hF);
        bus_write(8'h10, 32'h1);
        bus_read(8'h20, rv); check("snapclr_keep", rv, 32'h1);

        // mask, irq, W1C vs set
        bus_write(8'h08, 32'hFFFF_FFFF);
        bus_write(8'h0C, 32'hFFFF_FFFF);
        bus_read(8'h0C, rv); check("mask_impl", rv, 32'h0007_000F);
        bus_write(8'h0C, 32'h0001_0000);
        repeat (2) @(negedge sys_clk);
        check("irq_idle", {31'b0, irq}, 32'h0);
        @(negedge sys_clk); mem_err = 3'b001;
        @(negedge sys_clk); mem_err = '0;
        @(negedge sys_clk);
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_write(8'h08, 32'h0001_0000);
        @(negedge sys_clk);
        check("irq_clr", {31'b0, irq}, 32'h0);
        bus_read(8'h08, rv); check("sticky_cleared", rv, 32'h0);
        mem_err = 3'b001;
        repeat (2) @(negedge sys_clk);
        bus_write(8'h08, 32'h0001_0000);
        @(negedge sys_clk);
        check("irq_hold", {31'b0, irq}, 32'h1);
        bus_read(8'h08, rv); check("sticky_set_wins", rv, 32'h0001_0000);
        mem_err = '0;

        // read and write together: read wins, write dropped
        @(negedge sys_clk);
        csn = 1'b0; rdn = 1'b0; wrn = 1'b0; addr = 8'h0C; dout = 32'h0;
        @(negedge sys_clk);
        csn = 1'b1; rdn = 1'b1; wrn = 1'b1;
        check("rdwr_din", din, 32'h0001_0000);
        bus_read(8'h0C, rv); check("rdwr_mask", rv, 32'h0001_0000);

        // 4-cycle CLR strobe, event after the first cycle survives
        pulse_err(4'b0010, 3);
        @(negedge sys_clk);
        csn = 1'b0; wrn = 1'b0; addr = 8'h10; dout = 32'h2;
        @(negedge sys_clk); link_err = 4'b0010;
        @(negedge sys_clk); link_err = '0;
        @(negedge sys_clk);
        @(negedge sys_clk); csn = 1'b1; wrn = 1'b1;
        bus_write(8'h10, 32'h1);
        bus_read(8'h24, rv); check("clr_once", rv, 32'h1);

        // async reset mid-count with links up
        link_up = 4'hF; link_err = 4'hF; mem_err = 3'b001;
        repeat (3) @(negedge sys_clk);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        bus_read(8'h00, rv); check("pre_rst_din", rv, 32'h5045_0402);
        @(posedge sys_clk); #3;
        sys_rst_n = 1'b0;
        #1;
        check("arst_irq", {31'b0, irq}, 32'h0);
        check("arst_din", din, 32'h0);
        link_err = '0; mem_err = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        bus_read(8'h08, rv); check("post_rst_sticky", rv, 32'h0);
        bus_read(8'h0C, rv); check("post_rst_mask", rv, 32'h0);
        bus_write(8'h10, 32'h1);
        for (int i = 0; i < N_LINK; i++) begin
            bus_read(8'(32 + 4 * i), rv);
            check($sformatf("post_rst_snap%0d", i), rv, 32'h0);
        end
        link_up = 4'h7;
        repeat (2) @(negedge sys_clk);
        bus_read(8'h08, rv); check("post_rst_fall", rv, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
